// File: rtl/noise_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// noise_ctrl_pkg : FSM states, LFSR constants and noise helper shared by
//                  noise_burst_ctrl and lfsr16_step.
// Revision       : 1.0
// ============================================================================
package noise_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SEED   = 3'd1,
    ST_WARMUP = 3'd2,
    ST_BURST  = 3'd3,
    ST_GAP    = 3'd4
  } state_e;

  localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;
  // Feedback taps at bits 15, 13, 12 and 10.
  localparam logic [15:0] LFSR_TAPS         = 16'hB400;
  localparam logic [4:0]  NOISE_OFFSET      = 5'd8;

  function automatic logic signed [4:0] noise_from_nibble(input logic [3:0] nib,
                                                          input logic [1:0] shift);
    logic signed [4:0] n;
    n = $signed({1'b0, nib} - NOISE_OFFSET);
    return n >>> shift;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lfsr16_step.sv
`default_nettype none
// ============================================================================
// lfsr16_step : 16-bit left-shifting Fibonacci LFSR with load and step enable.
// Revision    : 1.0
// ============================================================================
module lfsr16_step
  import noise_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic        en_i,
  input  logic [15:0] seed_i,
  output logic [15:0] state_o
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (load_i) begin
      lfsr_d = seed_i;
    end else if (en_i) begin
      lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= LFSR_DEFAULT_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign state_o = lfsr_q;

endmodule
`default_nettype wire

// File: rtl/noise_burst_ctrl.sv
`default_nettype none
// ============================================================================
// noise_burst_ctrl : injects scaled LFSR noise into a valid/ready sample stream
//                    in programmable bursts. NOISE_BURST_SAT_EN selects a
//                    saturating sum instead of two's-complement wrap.
// Revision         : 1.0
// ============================================================================
module noise_burst_ctrl
  import noise_ctrl_pkg::*;
#(
  parameter int DW     = 8,
  parameter int CNT_W  = 16,
  parameter int WARMUP = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [15:0]      cfg_seed,
  input  logic [CNT_W-1:0] cfg_burst_len,
  input  logic [CNT_W-1:0] cfg_gap_len,
  input  logic [1:0]       cfg_shift,
  input  logic             start,
  input  logic             stop,
  output logic             busy,
  output logic             burst_done,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    out_data,
  output logic             out_noisy
);

  localparam logic [CNT_W-1:0] WARM_LAST = (WARMUP > 0) ? CNT_W'(WARMUP - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_e           state_q;
  logic [15:0]      seed_q;
  logic [CNT_W-1:0] burst_len_q;
  logic [CNT_W-1:0] gap_len_q;
  logic [1:0]       shift_q;
  logic [CNT_W-1:0] cnt_q;

  logic             out_valid_q;
  logic [DW-1:0]    out_data_q;
  logic             out_noisy_q;

  logic [15:0]       w_lfsr;
  logic              w_unused_lfsr;
  logic              w_accept;
  logic              w_noisy;
  logic [CNT_W-1:0]  w_cnt_inc;
  logic              w_burst_last;
  logic              w_gap_last;
  logic signed [4:0] w_noise;
  logic [DW-1:0]     w_res;

  assign w_accept     = in_valid && in_ready;
  assign w_noisy      = (state_q == ST_BURST);
  assign w_cnt_inc    = cnt_q + CNT_ONE;
  assign w_burst_last = w_noisy && w_accept && (burst_len_q != '0) && (w_cnt_inc == burst_len_q);
  assign w_gap_last   = (state_q == ST_GAP) && w_accept && (w_cnt_inc == gap_len_q);

  lfsr16_step u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .load_i (state_q == ST_SEED),
    .en_i   ((state_q == ST_WARMUP) || (w_noisy && w_accept)),
    .seed_i (seed_q),
    .state_o(w_lfsr)
  );

  assign w_unused_lfsr = ^{w_lfsr[15:12], w_lfsr[7:0]};
  assign w_noise       = noise_from_nibble(w_lfsr[11:8], shift_q);

`ifdef NOISE_BURST_SAT_EN
  logic [DW:0] w_sum;
  assign w_sum = {in_data[DW-1], in_data} + {{(DW-4){w_noise[4]}}, w_noise};

  always_comb begin
    w_res = w_sum[DW-1:0];
    // Top two bits disagree only on overflow; the top bit gives the direction.
    if (w_sum[DW] != w_sum[DW-1]) begin
      w_res = w_sum[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    end
  end
`else
  logic [DW-1:0] w_sum;
  assign w_sum = in_data + {{(DW-5){w_noise[4]}}, w_noise};
  assign w_res = w_sum;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      seed_q      <= LFSR_DEFAULT_SEED;
      burst_len_q <= '0;
      gap_len_q   <= '0;
      shift_q     <= 2'd0;
      cnt_q       <= '0;
    end else begin
      if ((state_q == ST_IDLE) && cfg_we) begin
        seed_q      <= (cfg_seed == 16'h0000) ? LFSR_DEFAULT_SEED : cfg_seed;
        burst_len_q <= cfg_burst_len;
        gap_len_q   <= cfg_gap_len;
        shift_q     <= cfg_shift;
      end
      if (stop) begin
        state_q <= ST_IDLE;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (start) state_q <= ST_SEED;
          end
          ST_SEED: begin
            cnt_q   <= '0;
            state_q <= (WARMUP == 0) ? ST_BURST : ST_WARMUP;
          end
          ST_WARMUP: begin
            if (cnt_q == WARM_LAST) begin
              cnt_q   <= '0;
              state_q <= ST_BURST;
            end else begin
              cnt_q <= w_cnt_inc;
            end
          end
          ST_BURST: begin
            if (w_burst_last) begin
              cnt_q <= '0;
              if (gap_len_q != '0) state_q <= ST_GAP;
            end else if (w_accept && (burst_len_q != '0)) begin
              cnt_q <= w_cnt_inc;
            end
          end
          ST_GAP: begin
            if (w_gap_last) begin
              cnt_q   <= '0;
              state_q <= ST_BURST;
            end else if (w_accept) begin
              cnt_q <= w_cnt_inc;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_noisy_q <= 1'b0;
    end else if (w_accept) begin
      out_valid_q <= 1'b1;
      out_data_q  <= w_noisy ? w_res : in_data;
      out_noisy_q <= w_noisy;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign in_ready   = !out_valid_q || out_ready;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_noisy  = out_noisy_q;
  assign busy       = (state_q != ST_IDLE);
  assign burst_done = w_burst_last;

endmodule
`default_nettype wire

// File: doc/noise_burst_ctrl.md
# noise_burst_ctrl

Sequencer for the 16-bit LFSR noise datapath. It loads a seed, warms the LFSR up, then injects scaled pseudo-random noise into a streaming signed sample path in programmable bursts separated by clean gaps. Samples outside a burst pass through unmodified. The block sits between the signal source and downstream consumers, and replaces free-running noise addition with a start/stop-controlled, back-pressure-aware schedule.

## Interface
Parameters:
- `DW`, 8, sample width (signed)
- `CNT_W`, 16, burst/gap counter width
- `WARMUP`, 16, LFSR warm-up steps after seeding; 0 skips warm-up

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset; synchronous, active-high
- `cfg_we`  in  1  latch config fields; ignored while `busy`
- `cfg_seed`  in  16  LFSR seed; 0 is replaced by 16'hACE1
- `cfg_burst_len`  in  CNT_W  noisy samples per burst; 0 = continuous
- `cfg_gap_len`  in  CNT_W  clean samples between bursts; 0 = back-to-back bursts
- `cfg_shift`  in  2  noise arithmetic right-shift (attenuation)
- `start`  in  1  begin sequence (pulse); ignored while `busy`
- `stop`  in  1  abort to IDLE (pulse); wins over a simultaneous `start`
- `busy`  out  1  high in any state other than IDLE
- `burst_done`  out  1  one-cycle pulse when the last sample of a burst is accepted
- `in_valid`  in  1  / `in_ready` out 1 / `in_data` in DW signed: input stream
- `out_valid`  out  1  / `out_ready` in 1 / `out_data` out DW signed: output stream
- `out_noisy`  out  1  qualifies `out_data`: noise was added

## Operation
- LFSR: 16-bit, shift left, `fb = q[15]^q[13]^q[12]^q[10]` inserted at bit 0.
- Noise: `n = {1'b0,q[11:8]} - 8` (5-bit signed, range -8..+7), then `n >>> cfg_shift`.
- Sum: `in_data + n` computed in DW+1 bits; the result is truncated or saturated per Configuration.
- FSM states:
  - IDLE→SEED on `start`.
  - SEED (1 cycle): load the seed and clear the counters. SEED→WARMUP, or →BURST if `WARMUP`=0.
  - WARMUP: step the LFSR once per cycle for `WARMUP` cycles, independent of stream traffic. →BURST.
  - BURST: each accepted sample gets noise, the LFSR steps, and the burst counter increments. When the count reaches `cfg_burst_len`, pulse `burst_done` and go →GAP, or →BURST with the counter cleared if the gap is 0. With `cfg_burst_len`=0 the FSM never leaves BURST.
  - GAP: accepted samples pass clean and the LFSR holds. After `cfg_gap_len` samples go →BURST.
- `stop` in any state → IDLE next cycle. The LFSR holds its value. An in-flight output register is not discarded.
- In IDLE, SEED and WARMUP, samples pass clean with `out_noisy`=0.
- Config is latched on `cfg_we` only in IDLE. The reset config is seed 16'hACE1, burst 0, gap 0, shift 0.

## Timing
- Stream: single output register.
  - `in_ready = !out_valid || out_ready`.
  - Transfer occurs when `in_valid && in_ready`, and `out_data` appears the next cycle (latency 1).
  - `out_valid` drops when `out_ready` is high and no new input is accepted.
  - Throughput is 1 sample/cycle with back-pressure.
- Noise for a sample uses the LFSR value before that cycle's step. Noisy/clean is decided by the FSM state in the accept cycle.
- `burst_done` asserts in the accept cycle of the final burst sample.
- Reset (synchronous): state IDLE, LFSR 16'hACE1, counters 0. All outputs are 0 except `in_ready`=1.
- `rst` mid-burst: the above values apply on the next edge, and any pending output is dropped.
- `start` and `stop` together: `stop` wins and the FSM stays in IDLE.

## Configuration
- `NOISE_BURST_SAT_EN` defined: the sum saturates to [-2^(DW-1), 2^(DW-1)-1].
- Not defined: the sum wraps (two's-complement truncation to DW bits).

## Structure
- Package `noise_ctrl_pkg`:
  - FSM state enum (IDLE, SEED, WARMUP, BURST, GAP)
  - `LFSR_DEFAULT_SEED` = 16'hACE1
  - tap constants
  - noise offset 8
- Sub-module `lfsr16_step`: load/enable/seed in, state out. It is instantiated once.

## Test plan
- `WARMUP`=0, seed ACE1, shift 0, burst 3, gap 2, `in_data`=0 streamed, `out_ready`=1:
  - outputs are 4, 1, then the third burst sample with `out_noisy`=1, then 2 clean 0s, then noise resumes.
  - `burst_done` pulses on the 3rd accept.
- Seed 0 → identical output to seed ACE1.
- Saturation, `in_data`=127, first noise +4:
  - with `NOISE_BURST_SAT_EN`, output is 127;
  - without it, output is -125.
- `cfg_shift`=2, seed ACE1, `in_data`=0 → first output 1 (4>>>2).
- Back-pressure: hold `out_ready`=0 for 5 cycles mid-burst.
  - `in_ready`=0, and `out_data` and the LFSR are stable.
  - The burst count is unchanged and no sample is lost or duplicated.
- Control edge cases:
  - `stop` mid-burst → IDLE next cycle, `busy`=0, later samples clean.
  - `start`+`stop` in the same cycle → stays IDLE.
  - `rst` mid-GAP → all outputs return to reset values.
